// File: rtl/register_file.sv
// rtl/register_file.sv - RV64 integer register file, two combinational read ports, one write port
// x0 reads zero; a same-cycle write can be forwarded to the read ports when BYPASS_EN is set.
module register_file #(
    parameter int XLEN      = 64,
    parameter int NUM_REGS  = 32,
    parameter int BYPASS_EN = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   read_reg1,
    input  logic [AW-1:0]   read_reg2,
    input  logic            reg_write,
    input  logic [AW-1:0]   write_reg,
    input  logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2
);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            write_ok;
    logic            bypass1;
    logic            bypass2;

    // Entry 0 is never written, so it holds the reset value forever.
    assign write_ok = reg_write && (write_reg != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[write_reg] <= write_data;
        end
    end

    assign bypass1 = (BYPASS_EN != 0) && reg_write && (write_reg == read_reg1);
    assign bypass2 = (BYPASS_EN != 0) && reg_write && (write_reg == read_reg2);

    // Reset forces zero on the outputs so a pending write cannot leak through the bypass.
    assign read_data1 = (reset || read_reg1 == '0) ? '0 :
                        bypass1                    ? write_data :
                                                     regs[read_reg1];
    assign read_data2 = (reset || read_reg2 == '0) ? '0 :
                        bypass2                    ? write_data :
                                                     regs[read_reg2];

endmodule
